buffer_mux_arb: RTL and testbench

Parametrised successor to the fixed 3x32 buffered mux. It arbitrates NUM_IN valid/ready source channels of WIDTH bits onto one registered output channel. Arbitration is round-robin or fixed-priority, selected at run time. The block sits between multiple bus masters (for example register file, ALU and memory read paths) and a single shared datapath bus.

---
 rtl/buffer_mux_arb_if.sv | 29 ++
 rtl/buffer_mux_arb.sv | 117 +++++++++++
 tb/tb_buffer_mux_arb.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/buffer_mux_arb_if.sv
// Handshake bundle for buffer_mux_arb: NUM_IN source channels in, one registered channel out,
// plus read-only debug visibility of the arbitration state (round-robin pointer and lock flag).
interface buffer_mux_arb_if #(
  parameter int NUM_IN = 3,
  parameter int WIDTH  = 32,
  parameter int SELW   = $clog2(NUM_IN)
) ();
  logic [NUM_IN*WIDTH-1:0] IN_DATA;
  logic [NUM_IN-1:0]       IN_VALID;
  logic [NUM_IN-1:0]       IN_READY;
  logic [WIDTH-1:0]        OUT_DATA;
  logic                    OUT_VALID;
  logic                    OUT_READY;
  logic [SELW-1:0]         OUT_SEL;
  logic [SELW-1:0]         dbg_last;
  logic                    dbg_locked;

  // Valid/ready: a beat moves on any cycle where valid and ready are both high at the rising
  // edge; a source holds data stable while valid is high and its beat is not yet accepted.
  modport master (
    output IN_DATA, IN_VALID, OUT_READY,
    input  IN_READY, OUT_DATA, OUT_VALID, OUT_SEL, dbg_last, dbg_locked
  );

  modport slave (
    input  IN_DATA, IN_VALID, OUT_READY,
    output IN_READY, OUT_DATA, OUT_VALID, OUT_SEL, dbg_last, dbg_locked
  );
endinterface

// File: rtl/buffer_mux_arb.sv
// Round-robin / fixed-priority arbiter of NUM_IN valid/ready sources onto one registered output.
// Optional channel locking is compiled in with `define BUFFER_MUX_ARB_LOCK_EN.
module buffer_mux_arb #(
  parameter int NUM_IN = 3,
  parameter int WIDTH  = 32,
  parameter int SELW   = $clog2(NUM_IN)
) (
  input  logic              CLK,
  input  logic              N_RST,
  input  logic              MODE,
`ifdef BUFFER_MUX_ARB_LOCK_EN
  input  logic [NUM_IN-1:0] LOCK,
`endif
  buffer_mux_arb_if.slave   bus
);

  logic [WIDTH-1:0]  out_data_q;
  logic [SELW-1:0]   out_sel_q;
  logic              out_valid_q;
  logic [SELW-1:0]   last_q;
  logic              load;
  logic [NUM_IN-1:0] eligible;
  logic              grant_found;
  logic [SELW-1:0]   grant_idx;
  logic [WIDTH-1:0]  grant_data;
  logic [NUM_IN-1:0] in_ready;

  assign load = !out_valid_q || bus.OUT_READY;

`ifdef BUFFER_MUX_ARB_LOCK_EN
  logic            locked_q;
  logic [SELW-1:0] owner_q;

  // While locked, only the owner may compete, even if it is currently idle.
  always_comb begin
    eligible = bus.IN_VALID;
    if (locked_q) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (int'(owner_q) != i) eligible[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (N_RST) begin
      locked_q <= 1'b0;
      owner_q  <= '0;
    end else if (load && grant_found) begin
      locked_q <= LOCK[grant_idx];
      owner_q  <= grant_idx;
    end
  end

  assign bus.dbg_locked = locked_q;
`else
  assign eligible       = bus.IN_VALID;
  assign bus.dbg_locked = 1'b0;
`endif

  // Priority search: later loop iterations win, so iterate from the least preferred candidate.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    if (MODE) begin
      for (int i = NUM_IN - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          grant_found = 1'b1;
          grant_idx   = SELW'(i);
        end
      end
    end else begin
      for (int k = NUM_IN; k >= 1; k--) begin
        if (eligible[(int'(last_q) + k) % NUM_IN]) begin
          grant_found = 1'b1;
          grant_idx   = SELW'((int'(last_q) + k) % NUM_IN);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (int'(grant_idx) == i) grant_data = bus.IN_DATA[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    if (!N_RST && load && grant_found) in_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (N_RST) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      last_q      <= SELW'(NUM_IN - 1);
    end else if (load) begin
      if (grant_found) begin
        out_data_q  <= grant_data;
        out_sel_q   <= grant_idx;
        out_valid_q <= 1'b1;
        last_q      <= grant_idx;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_DATA  = out_data_q;
  assign bus.OUT_SEL   = out_sel_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.dbg_last  = last_q;

endmodule

// File: tb/tb_buffer_mux_arb.sv
// Directed bench for buffer_mux_arb (3 x 32): driver predicts grants, monitor checks output beats.
module tb_buffer_mux_arb;
  localparam int NUM_IN = 3;
  localparam int WIDTH  = 32;
  localparam int SELW   = 2;
  localparam int W      = SELW + WIDTH;

  logic CLK;
  logic N_RST;
  logic MODE;
  logic [NUM_IN-1:0] lock_v;
  logic [WIDTH-1:0]  src [NUM_IN];

  logic [W-1:0] exp_q[$];
  int checks;
  int errors;

  buffer_mux_arb_if #(.NUM_IN(NUM_IN), .WIDTH(WIDTH), .SELW(SELW)) bus ();

  buffer_mux_arb #(.NUM_IN(NUM_IN), .WIDTH(WIDTH), .SELW(SELW)) dut (
    .CLK   (CLK),
    .N_RST (N_RST),
    .MODE  (MODE),
`ifdef BUFFER_MUX_ARB_LOCK_EN
    .LOCK  (lock_v),
`endif
    .bus   (bus)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) bus.IN_DATA[i*WIDTH +: WIDTH] = src[i];
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Driver: apply inputs for one cycle, check IN_READY against the hand-computed grant,
  // and queue the beat that grant should produce.
  task automatic cycle(input logic [NUM_IN-1:0] v, input logic mode, input logic ordy,
                       input logic [NUM_IN-1:0] exp_rdy, input string name);
    bus.IN_VALID  = v;
    MODE          = mode;
    bus.OUT_READY = ordy;
    @(negedge CLK);
    check(name, 64'(bus.IN_READY), 64'(exp_rdy));
    for (int i = 0; i < NUM_IN; i++) begin
      if (exp_rdy[i]) exp_q.push_back({SELW'(i), src[i]});
    end
    @(posedge CLK);
    #1;
  endtask

  // Monitor / scoreboard: every output transfer must match the oldest queued beat.
  always @(negedge CLK) begin
    if (!N_RST && bus.OUT_VALID === 1'b1 && bus.OUT_READY === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_beat", 64'({bus.OUT_SEL, bus.OUT_DATA}), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("out_beat", 64'({bus.OUT_SEL, bus.OUT_DATA}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    N_RST = 1'b1;
    MODE = 1'b0;
    lock_v = '0;
    src[0] = 32'hA000_0000;
    src[1] = 32'hB111_1111;
    src[2] = 32'hC222_2222;
    bus.IN_VALID = 3'b111;
    bus.OUT_READY = 1'b1;

    // Reset and idle with all requests high
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_in_ready", 64'(bus.IN_READY), 64'h0);
    check("rst_out_valid", 64'(bus.OUT_VALID), 64'h0);
    check("rst_out_data", 64'(bus.OUT_DATA), 64'h0);
    check("rst_out_sel", 64'(bus.OUT_SEL), 64'h0);
    check("rst_last", 64'(bus.dbg_last), 64'd2);
    @(posedge CLK);
    #1;
    N_RST = 1'b0;

    // Round-robin fairness, back-to-back
    cycle(3'b111, 1'b0, 1'b1, 3'b001, "rr_g0");
    cycle(3'b111, 1'b0, 1'b1, 3'b010, "rr_g1");
    cycle(3'b111, 1'b0, 1'b1, 3'b100, "rr_g2");
    cycle(3'b111, 1'b0, 1'b1, 3'b001, "rr_g0b");
    cycle(3'b111, 1'b0, 1'b1, 3'b010, "rr_g1b");
    cycle(3'b111, 1'b0, 1'b1, 3'b100, "rr_g2b");
    cycle(3'b000, 1'b0, 1'b1, 3'b000, "rr_idle");
    check("idle_out_valid", 64'(bus.OUT_VALID), 64'h0);
    check("idle_out_sel_hold", 64'(bus.OUT_SEL), 64'd2);

    // Fixed priority
    cycle(3'b110, 1'b1, 1'b1, 3'b010, "fp_110_a");
    cycle(3'b110, 1'b1, 1'b1, 3'b010, "fp_110_b");
    cycle(3'b111, 1'b1, 1'b1, 3'b001, "fp_111");
    cycle(3'b100, 1'b1, 1'b1, 3'b100, "fp_100");
    cycle(3'b000, 1'b1, 1'b1, 3'b000, "fp_idle");

    // Backpressure after a ch1 beat; LAST is 2 here so a lone ch1 request is granted
    src[1] = 32'h1234_5678;
    cycle(3'b010, 1'b0, 1'b1, 3'b010, "bp_load_ch1");
    for (int i = 0; i < 4; i++) begin
      cycle(3'b111, 1'b0, 1'b0, 3'b000, "bp_stall_ready");
      check("bp_stall_data", 64'(bus.OUT_DATA), 64'h1234_5678);
      check("bp_stall_sel", 64'(bus.OUT_SEL), 64'd1);
      check("bp_stall_valid", 64'(bus.OUT_VALID), 64'h1);
    end
    src[1] = 32'hB111_1111;
    cycle(3'b111, 1'b0, 1'b1, 3'b100, "bp_release_g2");

    // Reset mid-stall discards the pending ch2 beat
    cycle(3'b111, 1'b0, 1'b0, 3'b000, "ms_stall");
    N_RST = 1'b1;
    exp_q.delete();
    cycle(3'b111, 1'b0, 1'b0, 3'b000, "ms_in_reset");
    N_RST = 1'b0;
    check("ms_out_valid", 64'(bus.OUT_VALID), 64'h0);
    check("ms_last", 64'(bus.dbg_last), 64'd2);
    cycle(3'b111, 1'b0, 1'b1, 3'b001, "ms_first_g0");
    cycle(3'b000, 1'b0, 1'b1, 3'b000, "ms_idle");

`ifdef BUFFER_MUX_ARB_LOCK_EN
    // Lock on ch2, others starve while it idles, then unlock resumes round-robin at ch0
    lock_v = 3'b100;
    cycle(3'b100, 1'b0, 1'b1, 3'b100, "lk_take");
    check("lk_locked", 64'(bus.dbg_locked), 64'h1);
    lock_v = 3'b000;
    cycle(3'b011, 1'b0, 1'b1, 3'b000, "lk_block_a");
    cycle(3'b011, 1'b1, 1'b1, 3'b000, "lk_block_b");
    cycle(3'b111, 1'b1, 1'b1, 3'b100, "lk_release");
    check("lk_unlocked", 64'(bus.dbg_locked), 64'h0);
    cycle(3'b011, 1'b0, 1'b1, 3'b001, "lk_after_g0");
    cycle(3'b000, 1'b0, 1'b1, 3'b000, "lk_idle");
`endif

    repeat (3) @(posedge CLK);
    #1;
    check("exp_q_drained", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
